alu_result_serializer: RTL and testbench

Downstream stage of the ALU logic/arithmetic units: captures each WIDTH-bit result on its one-cycle valid flag and streams it LSB-byte-first over an 8-bit valid/ready link to the UART transmit path. A one-entry pending buffer absorbs a second result that arrives while a frame is still being sent. Results that would overflow the buffer are dropped, and the loss is flagged with a sticky overrun bit.

---
 rtl/alu_sys_pkg.sv | 18 +
 rtl/alu_res_hold.sv | 49 ++++
 rtl/alu_result_serializer.sv | 136 +++++++++++++
 tb/tb_alu_result_serializer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_sys_pkg.sv
// alu_sys_pkg
//   Shared definitions for the ALU result output path: byte width, the
//   serializer FSM state type and the bytes-per-frame derivation.
package alu_sys_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Number of bytes in a frame carrying a width-bit result.
  function automatic int unsigned nbytes_f(input int unsigned width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/alu_res_hold.sv
// alu_res_hold
//   One-entry holding buffer for an ALU result waiting behind the frame
//   currently being serialized.
//   Ports:
//     clk, rst   clock, synchronous active-high reset (empties the buffer)
//     wr, din    write strobe and data; a write always leaves the buffer full
//     rd         read/pop strobe; rd together with wr replaces the contents
//     dout, full stored result and occupancy flag
module alu_res_hold #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (rd) begin
      full_d = 1'b0;
    end
    if (wr) begin
      data_d = din;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer
//   Captures a WIDTH-bit ALU result on its one-cycle strobe and streams it
//   LSB byte first over an 8-bit valid/ready link. One further result can
//   wait in a pending buffer; any result beyond that is dropped and flagged
//   in the sticky overrun bit.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     res_data, res_valid  result and its one-cycle strobe
//     tx_data, tx_valid    byte stream towards the UART transmit path
//     tx_ready             consumer accept (transfer = tx_valid && tx_ready)
//     busy                 frame active or pending buffer occupied
//     overrun, ovr_clr     sticky drop flag and its clear (set wins)
module alu_result_serializer
  import alu_sys_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] res_data,
  input  logic             res_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int unsigned NBYTES = nbytes_f(WIDTH);
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic             overrun_q, overrun_d;

  logic             hold_wr, hold_rd, hold_full;
  logic [WIDTH-1:0] hold_dout;
  logic             xfer, last_xfer, ovr_set;

  alu_res_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .wr   (hold_wr),
    .rd   (hold_rd),
    .din  (res_data),
    .dout (hold_dout),
    .full (hold_full)
  );

  assign xfer      = (state_q == SEND) && tx_ready;
  assign last_xfer = xfer && (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    hold_wr = 1'b0;
    hold_rd = 1'b0;
    ovr_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (res_valid) begin
          act_d   = res_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_xfer) begin
          // Next frame starts on the same edge so back-to-back frames
          // have no bubble; the pending entry is older and goes first.
          if (hold_full) begin
            act_d   = hold_dout;
            idx_d   = '0;
            hold_rd = 1'b1;
            hold_wr = res_valid;
          end else if (res_valid) begin
            act_d = res_data;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (res_valid) begin
            if (hold_full) begin
              ovr_set = 1'b1;
            end else begin
              hold_wr = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    overrun_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      act_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      act_q     <= act_d;
      overrun_q <= overrun_d;
    end
  end

  // Byte select decoded from registered state only.
  always_comb begin
    tx_data = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        tx_data = act_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign tx_valid = (state_q == SEND);
  assign busy     = (state_q == SEND) || hold_full;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
module tb_alu_result_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] res_data;
  logic        res_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overrun;
  logic        ovr_clr;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cycle  = 0;

  logic [7:0]  got_q[$];
  int unsigned got_cyc[$];
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  alu_result_serializer #(
    .WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .res_data  (res_data),
    .res_valid (res_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  // Inputs change just after posedge, so values seen at negedge are the
  // ones the next rising edge will act on.
  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (!rst && tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      got_cyc.push_back(cycle);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stream();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic check_stream(input string tag, input bit no_gap);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i),
            (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hxxxxxxxx,
            {24'h0, exp_q[i]});
      if (no_gap && i > 0 && i < got_cyc.size()) begin
        check($sformatf("%s_gap%0d", tag, i), got_cyc[i] - got_cyc[i-1], 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; res_data = '0; res_valid = 1'b0; tx_ready = 1'b0; ovr_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tx_data", tx_data, 0);

    // Basic frame
    clear_stream();
    tx_ready = 1'b1; res_data = 16'hA55A; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check("basic_b0_valid", tx_valid, 1);
    check("basic_b0_data", tx_data, 8'h5A);
    tick();
    check("basic_b1_data", tx_data, 8'hA5);
    tick();
    check("basic_end_valid", tx_valid, 0);
    check("basic_end_busy", busy, 0);
    exp_q = '{8'h5A, 8'hA5};
    check_stream("basic", 1'b1);

    // Backpressure
    clear_stream();
    tx_ready = 1'b0; res_data = 16'h1234; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_data", i), tx_data, 8'h34);
      check($sformatf("stall%0d_valid", i), tx_valid, 1);
      if (i < 4) tick();
    end
    tx_ready = 1'b1;
    tick();
    check("bp_b1_data", tx_data, 8'h12);
    tick();
    check("bp_end_valid", tx_valid, 0);
    tick();
    exp_q = '{8'h34, 8'h12};
    check_stream("bp", 1'b0);

    // Pending path
    clear_stream();
    res_data = 16'h1111; res_valid = 1'b1;
    tick();
    res_data = 16'h2222;
    tick();
    res_valid = 1'b0;
    check("pend_busy", busy, 1);
    repeat (4) tick();
    check("pend_idle_busy", busy, 0);
    check("pend_overrun", overrun, 0);
    exp_q = '{8'h11, 8'h11, 8'h22, 8'h22};
    check_stream("pend", 1'b1);

    // Overrun
    clear_stream();
    tx_ready = 1'b0;
    res_data = 16'hAAAA; res_valid = 1'b1; tick();
    res_data = 16'hBBBB; tick();
    res_data = 16'hCCCC; tick();
    res_valid = 1'b0;
    check("ovr_set", overrun, 1);
    check("ovr_busy", busy, 1);
    tx_ready = 1'b1;
    repeat (6) tick();
    check("ovr_sticky", overrun, 1);
    check("ovr_drained", tx_valid, 0);
    exp_q = '{8'hAA, 8'hAA, 8'hBB, 8'hBB};
    check_stream("ovr", 1'b1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("ovr_clr", overrun, 0);

    // Capture in the same cycle as the last-byte transfer
    clear_stream();
    res_data = 16'h0102; res_valid = 1'b1; tick();
    res_valid = 1'b0; tick();
    res_data = 16'hBEEF; res_valid = 1'b1; tick();
    res_valid = 1'b0;
    check("simul_b0_data", tx_data, 8'hEF);
    repeat (3) tick();
    check("simul_overrun", overrun, 0);
    exp_q = '{8'h02, 8'h01, 8'hEF, 8'hBE};
    check_stream("simul", 1'b1);

    // Mid-frame reset
    clear_stream();
    res_data = 16'hCAFE; res_valid = 1'b1; tick();
    res_valid = 1'b0; tick();
    rst = 1'b1; tx_ready = 1'b0; tick();
    check("mrst_valid", tx_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_data", tx_data, 0);
    rst = 1'b0; tx_ready = 1'b1;
    repeat (3) tick();
    check("mrst_idle", tx_valid, 0);
    exp_q = '{8'hFE};
    check_stream("mrst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
